// File: rtl/bulk_read_arbiter.sv
// Round-robin arbiter sharing one downstream bulk-line port among NUM_REQ requesters.
// Reads hold the grant until their line returns; writes release it on the accept handshake.
module bulk_read_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int LINE_SIZE = 16,
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 32,
    localparam int GNT_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int STRB_W   = DATA_W / 8
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic [NUM_REQ-1:0]                            up_req_valid_i,
    output logic [NUM_REQ-1:0]                            up_req_ready_o,
    input  logic [NUM_REQ-1:0]                            up_req_write_i,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]                up_req_addr_i,
    input  logic [NUM_REQ-1:0][LINE_SIZE-1:0][DATA_W-1:0] up_req_wdata_i,
    input  logic [NUM_REQ-1:0][LINE_SIZE-1:0][STRB_W-1:0] up_req_wstrb_i,
    output logic [NUM_REQ-1:0]                            up_resp_valid_o,
    output logic [LINE_SIZE-1:0][DATA_W-1:0]              up_resp_rdata_o,
    output logic                                          dn_req_valid_o,
    input  logic                                          dn_req_ready_i,
    output logic                                          dn_req_write_o,
    output logic [ADDR_W-1:0]                             dn_req_addr_o,
    output logic [LINE_SIZE-1:0][DATA_W-1:0]              dn_req_wdata_o,
    output logic [LINE_SIZE-1:0][STRB_W-1:0]              dn_req_wstrb_o,
    input  logic                                          dn_resp_valid_i,
    input  logic [LINE_SIZE-1:0][DATA_W-1:0]              dn_resp_rdata_i,
    output logic [GNT_W-1:0]                              grant_id_o,
    output logic                                          busy_o,
    output logic                                          err_unexpected_resp_o
);

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [GNT_W-1:0]   grant_q, grant_d;
    logic [GNT_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               err_q, err_d;
    logic               arb_found_s;
    logic [GNT_W-1:0]   arb_idx_s;

    function automatic logic [GNT_W-1:0] next_ptr(input logic [GNT_W-1:0] g);
        if (int'(g) == NUM_REQ - 1) begin
            return '0;
        end else begin
            return g + GNT_W'(1);
        end
    endfunction

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int               cand;
        logic [GNT_W-1:0] cand_idx;
        arb_found_s = 1'b0;
        arb_idx_s   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand     = (int'(rr_ptr_q) + i) % NUM_REQ;
            cand_idx = GNT_W'(cand);
            if (!arb_found_s && up_req_valid_i[cand_idx]) begin
                arb_found_s = 1'b1;
                arb_idx_s   = cand_idx;
            end else begin
                arb_found_s = arb_found_s;
            end
        end
    end

    // Next-state logic and the combinational request/response routing.
    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        rr_ptr_d        = rr_ptr_q;
        err_d           = err_q | (dn_resp_valid_i && (state_q != RESP));
        up_req_ready_o  = '0;
        up_resp_valid_o = '0;
        dn_req_valid_o  = 1'b0;
        dn_req_write_o  = 1'b0;
        dn_req_addr_o   = '0;
        dn_req_wdata_o  = '0;
        dn_req_wstrb_o  = '0;
        case (state_q)
            ARB: begin
                if (arb_found_s) begin
                    grant_d = arb_idx_s;
                    state_d = REQ;
                end else begin
                    state_d = ARB;
                end
            end
            REQ: begin
                dn_req_valid_o          = up_req_valid_i[grant_q];
                dn_req_write_o          = up_req_write_i[grant_q];
                dn_req_addr_o           = up_req_addr_i[grant_q];
                dn_req_wdata_o          = up_req_wdata_i[grant_q];
                dn_req_wstrb_o          = up_req_wstrb_i[grant_q];
                up_req_ready_o[grant_q] = dn_req_ready_i;
                if (up_req_valid_i[grant_q] && dn_req_ready_i) begin
                    if (up_req_write_i[grant_q]) begin
                        rr_ptr_d = next_ptr(grant_q);
                        state_d  = ARB;
                    end else begin
                        state_d  = RESP;
                    end
                end else if (!up_req_valid_i[grant_q]) begin
                    // Requester withdrew: give up the grant without advancing fairness.
                    state_d = ARB;
                end else begin
                    state_d = REQ;
                end
            end
            RESP: begin
                if (dn_resp_valid_i) begin
                    up_resp_valid_o[grant_q] = 1'b1;
                    rr_ptr_d                 = next_ptr(grant_q);
                    state_d                  = ARB;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = ARB;
            end
        endcase
    end

    // State, grant, fairness pointer and sticky error registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ARB;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
        end
    end

    assign up_resp_rdata_o       = dn_resp_rdata_i;
    assign grant_id_o            = grant_q;
    assign busy_o                = (state_q != ARB);
    assign err_unexpected_resp_o = err_q;

endmodule

// File: doc/bulk_read_arbiter.md
Name: bulk_read_arbiter

Overview:
- Round-robin arbiter that shares one downstream bulk-line port between NUM_REQ bulk-line requesters, e.g. I-cache refill and D-cache refill/writeback.
- Downstream is the bulk-line-to-AXI adapter.
- Reads are tracked until their line response returns and are routed back to the owner.
- Writes are posted: the accept handshake is their completion, and the grant is released immediately.

Parameters:
- NUM_REQ, 2, number of upstream requesters (≥2).
- LINE_SIZE, 16, beats per line.
- DATA_W, 64, beat width in bits.
- ADDR_W, 32, request address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- up_req_valid  in  NUM_REQ  per-requester request valid
- up_req_ready  out  NUM_REQ  per-requester accept
- up_req_write  in  NUM_REQ  1=line write, 0=line read
- up_req_addr  in  NUM_REQ x ADDR_W  line address
- up_req_wdata  in  NUM_REQ x LINE_SIZE x DATA_W  write line
- up_req_wstrb  in  NUM_REQ x LINE_SIZE x DATA_W/8  write strobes
- up_resp_valid  out  NUM_REQ  one-cycle read-data-valid pulse, owner only
- up_resp_rdata  out  LINE_SIZE x DATA_W  read line, broadcast to all
- dn_req_valid  out  1  downstream request valid
- dn_req_ready  in  1  downstream accept (may depend combinationally on dn_req_write)
- dn_req_write  out  1
- dn_req_addr  out  ADDR_W
- dn_req_wdata  out  LINE_SIZE x DATA_W
- dn_req_wstrb  out  LINE_SIZE x DATA_W/8
- dn_resp_valid  in  1  one-cycle read completion
- dn_resp_rdata  in  LINE_SIZE x DATA_W
- grant_id  out  $clog2(NUM_REQ)  current owner
- busy  out  1  state != ARB
- err_unexpected_resp  out  1  sticky error flag

Behaviour:
- State machine:
  - ARB: no grant held.
  - REQ: grant held, request presented downstream.
  - RESP: read accepted, waiting for data.
- Reset (also applies mid-operation):
  - state=ARB, rr_ptr=0, grant_id=0, err_unexpected_resp=0.
  - All up_req_ready, up_resp_valid and dn_req_valid are 0; dn payload outputs are 0.
  - An in-flight downstream transaction is abandoned; downstream must be reset together with the arbiter.
- ARB:
  - Search up_req_valid starting at rr_ptr, ascending with wrap modulo NUM_REQ.
  - First set bit g: register grant_id=g, next state REQ.
  - No valid: stay in ARB.
  - No ready or dn valid is asserted in ARB, so arbitration costs exactly 1 cycle.
- REQ:
  - dn_req_valid = up_req_valid[g]; dn_req_write/addr/wdata/wstrb = requester g fields; all pass through combinationally.
  - up_req_ready[g] = dn_req_ready; every other up_req_ready is 0.
  - Handshake (up_req_valid[g] & dn_req_ready) with write=1: rr_ptr=(g+1)%NUM_REQ, next state ARB.
  - Handshake with write=0: next state RESP.
  - up_req_valid[g] drops before handshake (protocol violation by requester): next state ARB, rr_ptr unchanged.
- RESP:
  - dn outputs are idle (valid=0, payload 0).
  - On dn_resp_valid: up_resp_valid[g]=1 in the same cycle (combinational), rr_ptr=(g+1)%NUM_REQ, next state ARB.
- up_resp_rdata = dn_resp_rdata at all times; consumers qualify it with their own up_resp_valid bit.
- dn_resp_valid while in ARB or REQ:
  - Ignored; no up_resp_valid is raised.
  - err_unexpected_resp is set and stays 1 until reset.
- Simultaneous requests: round-robin order. After a grant to g, g is lowest priority until every other valid requester has been served once.
- Throughput: back-to-back transactions have a 1-cycle ARB gap; the minimum is 2 cycles per write handshake.
- Requester rules: hold valid and payload stable until ready. Only one outstanding read per requester, which the arbiter guarantees by serialisation.
- grant_id is registered and holds its last value in ARB.

Test Plan:
- Single read from req0 addr 0x1000, dn_req_ready=1:
  - grant at cycle 1, handshake at cycle 1, state RESP.
  - dn_resp_valid at cycle 5 with rdata[0]=0xA5 → up_resp_valid=2'b01 in cycle 5, rdata[0]=0xA5, busy=0 in cycle 6.
- req0 and req1 both issue reads every cycle, rr_ptr=0:
  - grants alternate 0,1,0,1; each up_resp_valid pulse goes only to the owner; req1 is never starved.
- Write from req1 addr 0x2040, wdata[3]=0xDEAD, wstrb all 1s, dn_req_ready low for 3 cycles then high:
  - dn_req_wdata[3]=0xDEAD throughout; up_req_ready[1] is high only in the accept cycle.
  - Next cycle is ARB; no up_resp_valid is ever raised.
- Write from req0, then read from req1 pending:
  - req1 is granted in the ARB cycle after the write handshake.
  - No dn_req_valid is asserted while a read is in RESP.
- Spurious dn_resp_valid while in ARB → no up_resp_valid; err_unexpected_resp=1 and it holds until rst.
- rst asserted in RESP with a read pending:
  - Next cycle: state=ARB, busy=0, all ready and valid outputs 0, rr_ptr=0.
  - A later dn_resp_valid sets the error flag rather than producing a response.
